sisc_ctrl_mc: RTL and testbench
===============================

# sisc_ctrl_mc

Second-generation multi-cycle control FSM for the SISC processor. It sequences fetch/decode/execute/mem/writeback for the full ISA: NOOP, LOD, STR, ALU_OP, BRA, BRR, BNE and HLT. It adds a memory-ready handshake with a bounded wait and a terminal HALT state. It sits between the instruction register, status register, register file, ALU, PC and data memory, and drives all of their control inputs.

## Interface
- OP_W, 4: opcode width
- MM_W, 4: mode/condition-mask width; `stat` is also MM_W wide
- AM_IMM, 8: `mm` value selecting immediate ALU mode
- MEM_WAIT_MAX, 15: maximum MEM-state cycles waiting for `mem_ready`; must be ≥1
- clk  in  1  clock, rising edge
- rst_f  in  1  reset; asynchronous, active-low
- opcode  in  OP_W  from IR; stable from DECODE through WRITEBACK
- mm  in  MM_W  addressing mode / branch condition mask
- stat  in  MM_W  status flags (C, N, V, Z)
- mem_ready  in  1  data memory completes the current access
- resume  in  1  leave HALT (used only with CTRL_HALT_RESUME_EN)
- rf_we, wb_sel, rd_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load  out  1 each  datapath controls
- alu_op  out  2  00 = reg arith, 01 = imm arith, 10 = address calc, 11 = pass
- mem_req, dm_we  out  1 each  data memory request, write enable
- halted, mem_err  out  1 each  HLT reached; memory timeout
- state  out  3  present state: START0=0, START1=1, FETCH=2, DECODE=3, EXECUTE=4, MEM=5, WB=6, HALT=7

## Operation
- Opcode values: NOOP=0, LOD=1, STR=2, BRA=4, BRR=5, BNE=6, ALU_OP=8, HLT=15. Any other value executes as NOOP.
- Transitions:
  - START0→START1→FETCH→DECODE.
  - DECODE→HALT if opcode==HLT, else EXECUTE.
  - EXECUTE→MEM→WB→FETCH.
  - MEM holds for LOD/STR until `mem_ready`. All other opcodes spend exactly 1 cycle in MEM.
- Outputs are combinational from the registered state plus opcode/mm/stat. Every output is 0 unless listed below.
- START0: pc_rst=1.
- FETCH: ir_load=1, pc_write=1, pc_sel=0 (PC+1).
- DECODE: rd_sel=1 when opcode==STR.
- EXECUTE:
  - ALU_OP: alu_op = 01 if mm==AM_IMM, else 00.
  - LOD/STR: alu_op=10.
  - Branch taken: pc_write=1, pc_sel=1, br_sel = 1 for BRR/BNE (relative), 0 for BRA (absolute).
  - BRA/BRR are taken when (stat & mm)≠0. BNE is taken when (stat & mm)==0.
- MEM:
  - LOD/STR: mem_req=1; dm_we=1 for STR.
  - A wait counter (width clog2(MEM_WAIT_MAX+1)) clears on MEM entry and increments each MEM cycle without `mem_ready`.
  - If the counter reaches MEM_WAIT_MAX with `mem_ready` still low, go to HALT and set sticky mem_err=1.
- WB: rf_we=1 for ALU_OP and LOD; wb_sel=1 for LOD (memory data), else 0.
- HALT: halted=1. mem_err holds its value. No other control is asserted.

## Timing
- While rst_f is low, asynchronously: state=START0, pc_rst=1, mem_err=0, wait counter=0. Every other output is 0.
- After rst_f rises: START0 lasts until the first clk edge, then one cycle in START1, then FETCH.
- Reset asserted mid-instruction (including mid-MEM wait) aborts immediately. No rf_we/dm_we pulse may follow.
- Latency per instruction:
  - 5 cycles (FETCH..WB) for non-memory opcodes.
  - 5+k cycles for LOD/STR, where k = cycles with `mem_ready` low; `mem_ready` already high on MEM entry gives k=0.
- HLT: 2 cycles (FETCH, DECODE), then HALT.
- `mem_ready` is sampled only in MEM for LOD/STR and ignored elsewhere.
- If `mem_ready` rises in the same cycle the counter reaches MEM_WAIT_MAX, completion wins: go to WB, no mem_err.
- rf_we and dm_we are each high for exactly one state visit per instruction. dm_we is high for every MEM cycle of a STR; memory latches its data on the `mem_ready` cycle.

## Configuration
- CTRL_HALT_RESUME_EN defined:
  - In HALT, `resume`=1 at a clk edge moves to FETCH and clears mem_err.
  - The PC is not reloaded, so execution continues at the instruction after HLT.
- Undefined: HALT is terminal until rst_f; `resume` is ignored.

## Test plan
- Reset release: rst_f low for 3 cycles, then high → pc_rst=1 through START0, then state sequence 1,2,3. ir_load=1 only in state 2.
- ALU immediate: opcode=8, mm=8 → alu_op=01 in EXECUTE, rf_we=1 and wb_sel=0 in WB, FETCH again 5 cycles after the previous FETCH.
- LOD with wait: opcode=1, mem_ready low 3 cycles then high → MEM lasts 4 cycles with mem_req=1, then WB with rf_we=1 and wb_sel=1.
- Branches:
  - BRR, stat=4'b0001, mm=4'b0001 → EXECUTE: pc_write=1, pc_sel=1, br_sel=1.
  - BNE under the same values → not taken, pc_write=0.
- Timeout: STR with mem_ready held low and MEM_WAIT_MAX=15 → state=7 after 15 MEM cycles, mem_err=1, dm_we=0 in HALT.
- HLT and resume: opcode=15 → halted=1. With CTRL_HALT_RESUME_EN, a resume pulse gives state=2 on the next cycle; without it, state stays at 7.

Source files
------------

// File: rtl/sisc_ctrl_mc.sv
// sisc_ctrl_mc -- multi-cycle control FSM for the SISC processor.
//
// Sequences START0/START1 -> FETCH -> DECODE -> EXECUTE -> MEM -> WB for
// NOOP, LOD, STR, ALU_OP, BRA, BRR and BNE.  HLT, or a data-memory access
// that never completes, ends in HALT.  Unknown opcodes run as NOOP.
//
// Optional feature: define CTRL_HALT_RESUME_EN to allow leaving HALT via
// `resume` (returns to FETCH and clears mem_err).  Undefined, HALT is
// terminal until rst_f.
//
// Ports:
//   clk, rst_f        clock (rising edge), asynchronous active-low reset
//   opcode, mm, stat  IR opcode, addressing mode / branch mask, status flags
//   mem_ready         data memory completes the current access
//   resume            leave HALT (CTRL_HALT_RESUME_EN builds only)
//   rf_we, wb_sel     register-file write enable, write-back source (1 = mem)
//   rd_sel            register read-port select (STR source register)
//   br_sel            branch target: 1 = relative, 0 = absolute
//   pc_rst, pc_write, pc_sel   PC reset, PC load, PC source (1 = branch)
//   ir_load           instruction register load
//   alu_op            00 reg arith, 01 imm arith, 10 address calc, 11 pass
//   mem_req, dm_we    data memory request / write enable
//   halted, mem_err   in HALT / sticky memory timeout
//   state             present state encoding
module sisc_ctrl_mc #(
   parameter int unsigned OP_W         = 4,
   parameter int unsigned MM_W         = 4,
   parameter int unsigned AM_IMM       = 8,
   parameter int unsigned MEM_WAIT_MAX = 15
) (
   input  logic            clk,
   input  logic            rst_f,
   input  logic [OP_W-1:0] opcode,
   input  logic [MM_W-1:0] mm,
   input  logic [MM_W-1:0] stat,
   input  logic            mem_ready,
   input  logic            resume,
   output logic            rf_we,
   output logic            wb_sel,
   output logic            rd_sel,
   output logic            br_sel,
   output logic            pc_rst,
   output logic            pc_write,
   output logic            pc_sel,
   output logic            ir_load,
   output logic [1:0]      alu_op,
   output logic            mem_req,
   output logic            dm_we,
   output logic            halted,
   output logic            mem_err,
   output logic [2:0]      state
);

   localparam int unsigned CNT_W = $clog2(MEM_WAIT_MAX + 1);
   // Last counter value before the increment that would reach MEM_WAIT_MAX.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

   localparam logic [OP_W-1:0] OP_LOD = OP_W'(1);
   localparam logic [OP_W-1:0] OP_STR = OP_W'(2);
   localparam logic [OP_W-1:0] OP_BRA = OP_W'(4);
   localparam logic [OP_W-1:0] OP_BRR = OP_W'(5);
   localparam logic [OP_W-1:0] OP_BNE = OP_W'(6);
   localparam logic [OP_W-1:0] OP_ALU = OP_W'(8);
   localparam logic [OP_W-1:0] OP_HLT = OP_W'(15);

   typedef enum logic [2:0] {
      ST_START0  = 3'd0,
      ST_START1  = 3'd1,
      ST_FETCH   = 3'd2,
      ST_DECODE  = 3'd3,
      ST_EXECUTE = 3'd4,
      ST_MEM     = 3'd5,
      ST_WB      = 3'd6,
      ST_HALT    = 3'd7
   } state_t;

   state_t           cur;
   state_t           nxt;
   logic [CNT_W-1:0] cnt;

   logic is_lod, is_str, is_bra, is_brr, is_bne, is_alu, is_hlt, is_mem;
   logic cond_hit, br_taken, imm_mode, timeout;

   assign is_lod   = (opcode == OP_LOD);
   assign is_str   = (opcode == OP_STR);
   assign is_bra   = (opcode == OP_BRA);
   assign is_brr   = (opcode == OP_BRR);
   assign is_bne   = (opcode == OP_BNE);
   assign is_alu   = (opcode == OP_ALU);
   assign is_hlt   = (opcode == OP_HLT);
   assign is_mem   = is_lod | is_str;
   assign imm_mode = (mm == MM_W'(AM_IMM));

   assign cond_hit = |(stat & mm);
   assign br_taken = ((is_bra | is_brr) & cond_hit) | (is_bne & ~cond_hit);

   // Ready in the final allowed cycle still completes the access.
   assign timeout  = (cur == ST_MEM) & is_mem & ~mem_ready & (cnt == CNT_LAST);

   assign state = cur;

`ifndef CTRL_HALT_RESUME_EN
   logic resume_unused;
   assign resume_unused = resume;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         cur <= ST_START0;
      end else begin
         cur <= nxt;
      end
   end

   // MEM wait counter and sticky timeout flag
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         cnt     <= '0;
         mem_err <= 1'b0;
      end else begin
         // EXECUTE always precedes MEM, so clearing here clears on MEM entry.
         if (cur == ST_EXECUTE) begin
            cnt <= '0;
         end else if ((cur == ST_MEM) && is_mem && !mem_ready) begin
            cnt <= cnt + CNT_W'(1);
         end

         if (timeout) begin
            mem_err <= 1'b1;
`ifdef CTRL_HALT_RESUME_EN
         end else if ((cur == ST_HALT) && resume) begin
            mem_err <= 1'b0;
`endif
         end
      end
   end

   // Next-state logic
   always_comb begin
      nxt = cur;
      unique case (cur)
         ST_START0:  nxt = ST_START1;
         ST_START1:  nxt = ST_FETCH;
         ST_FETCH:   nxt = ST_DECODE;
         ST_DECODE:  nxt = is_hlt ? ST_HALT : ST_EXECUTE;
         ST_EXECUTE: nxt = ST_MEM;
         ST_MEM: begin
            if (!is_mem || mem_ready) begin
               nxt = ST_WB;
            end else if (timeout) begin
               nxt = ST_HALT;
            end
         end
         ST_WB:      nxt = ST_FETCH;
         ST_HALT: begin
`ifdef CTRL_HALT_RESUME_EN
            if (resume) begin
               nxt = ST_FETCH;
            end
`endif
         end
      endcase
   end

   // Output logic
   always_comb begin
      rf_we    = 1'b0;
      wb_sel   = 1'b0;
      rd_sel   = 1'b0;
      br_sel   = 1'b0;
      pc_rst   = 1'b0;
      pc_write = 1'b0;
      pc_sel   = 1'b0;
      ir_load  = 1'b0;
      alu_op   = 2'b00;
      mem_req  = 1'b0;
      dm_we    = 1'b0;
      halted   = 1'b0;
      unique case (cur)
         ST_START0: pc_rst = 1'b1;
         ST_START1: ;
         ST_FETCH: begin
            ir_load  = 1'b1;
            pc_write = 1'b1;
            pc_sel   = 1'b0;
         end
         ST_DECODE: rd_sel = is_str;
         ST_EXECUTE: begin
            if (is_alu) begin
               alu_op = imm_mode ? 2'b01 : 2'b00;
            end else if (is_mem) begin
               alu_op = 2'b10;
            end
            if (br_taken) begin
               pc_write = 1'b1;
               pc_sel   = 1'b1;
               br_sel   = is_brr | is_bne;
            end
         end
         ST_MEM: begin
            if (is_mem) begin
               mem_req = 1'b1;
               dm_we   = is_str;
            end
         end
         ST_WB: begin
            rf_we  = is_alu | is_lod;
            wb_sel = is_lod;
         end
         ST_HALT: halted = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// tb_sisc_ctrl_mc -- scoreboard bench for sisc_ctrl_mc.
//
// A per-instruction reference model expands each planned instruction into
// its cycle-by-cycle expected control outputs.  The driver applies one row
// of inputs per clock and pushes that row's expectation; the monitor pops
// and compares on every falling edge.
module tb_sisc_ctrl_mc;

   localparam int unsigned WMAX = 15;

   logic       clk = 1'b0;
   logic       rst_f;
   logic [3:0] opcode, mm, stat;
   logic       mem_ready, resume;
   logic       rf_we, wb_sel, rd_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load;
   logic [1:0] alu_op;
   logic       mem_req, dm_we, halted, mem_err;
   logic [2:0] state;

   always #5 clk = ~clk;

   sisc_ctrl_mc #(
      .OP_W(4),
      .MM_W(4),
      .AM_IMM(8),
      .MEM_WAIT_MAX(WMAX)
   ) dut (
      .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
      .mem_ready(mem_ready), .resume(resume),
      .rf_we(rf_we), .wb_sel(wb_sel), .rd_sel(rd_sel), .br_sel(br_sel),
      .pc_rst(pc_rst), .pc_write(pc_write), .pc_sel(pc_sel), .ir_load(ir_load),
      .alu_op(alu_op), .mem_req(mem_req), .dm_we(dm_we), .halted(halted),
      .mem_err(mem_err), .state(state)
   );

   typedef struct packed {
      logic [2:0] state;
      logic       rf_we, wb_sel, rd_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load;
      logic [1:0] alu_op;
      logic       mem_req, dm_we, halted, mem_err;
   } out_t;

   typedef struct {
      logic       rst_f;
      logic [3:0] opcode, mm, stat;
      logic       mem_ready, resume;
      out_t       exp;
   } row_t;

   row_t stim_q[$];
   out_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   logic       m_err;                 // model's sticky timeout flag
   logic [3:0] cur_op, cur_mm, cur_stat;

   out_t got, mon_e;
   assign got = {state, rf_we, wb_sel, rd_sel, br_sel, pc_rst, pc_write, pc_sel,
                 ir_load, alu_op, mem_req, dm_we, halted, mem_err};

   function automatic string fmt(input out_t o);
      return $sformatf("st=%0d rf_we=%b wb_sel=%b rd_sel=%b br_sel=%b pc_rst=%b pc_write=%b pc_sel=%b ir_load=%b alu_op=%b mem_req=%b dm_we=%b halted=%b mem_err=%b",
                       o.state, o.rf_we, o.wb_sel, o.rd_sel, o.br_sel, o.pc_rst,
                       o.pc_write, o.pc_sel, o.ir_load, o.alu_op, o.mem_req,
                       o.dm_we, o.halted, o.mem_err);
   endfunction

   function automatic logic rnd1();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic out_t base(input logic [2:0] st);
      out_t o;
      o         = '0;
      o.state   = st;
      o.mem_err = m_err;
      return o;
   endfunction

   task automatic push(input out_t o, input logic rdy, input logic rst, input logic res);
      row_t r;
      r.rst_f     = rst;
      r.opcode    = cur_op;
      r.mm        = cur_mm;
      r.stat      = cur_stat;
      r.mem_ready = rdy;
      r.resume    = res;
      r.exp       = o;
      stim_q.push_back(r);
   endtask

   // n cycles held in reset, release cycle (still START0), then START1.
   task automatic reset_seq(input int n);
      out_t o;
      cur_op   = 4'($urandom);
      cur_mm   = 4'($urandom);
      cur_stat = 4'($urandom);
      m_err    = 1'b0;
      o        = base(3'd0);
      o.pc_rst = 1'b1;
      for (int i = 0; i < n; i++) push(o, rnd1(), 1'b0, rnd1());
      push(o, rnd1(), 1'b1, rnd1());
      o = base(3'd1);
      push(o, rnd1(), 1'b1, rnd1());
   endtask

   task automatic halt_exit(input int n);
      out_t o;
      o        = base(3'd7);
      o.halted = 1'b1;
`ifdef CTRL_HALT_RESUME_EN
      for (int i = 0; i < n; i++) push(o, rnd1(), 1'b1, 1'b0);
      push(o, rnd1(), 1'b1, 1'b1);
      m_err = 1'b0;
`else
      // resume toggles freely here and must not leave HALT
      for (int i = 0; i < n; i++) push(o, rnd1(), 1'b1, rnd1());
      reset_seq(2);
`endif
   endtask

   // k = MEM cycles with mem_ready low before it rises.  cut > 0 keeps only
   // the first cut cycles (the caller then aborts with reset).
   task automatic plan_instr(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s,
                             input int k, input int cut, output bit to_halt);
      out_t o;
      out_t rows[$];
      logic rdys[$];
      bit   lod, str, alu, memop, taken, tmo;
      int   nmem, n;
      lod   = (op == 4'd1);
      str   = (op == 4'd2);
      alu   = (op == 4'd8);
      memop = lod || str;
      taken = ((op == 4'd4 || op == 4'd5) && ((s & m) != 4'd0)) ||
              ((op == 4'd6) && ((s & m) == 4'd0));
      tmo     = 1'b0;
      to_halt = 1'b0;
      cur_op   = op;
      cur_mm   = m;
      cur_stat = s;

      o = base(3'd2); o.ir_load = 1'b1; o.pc_write = 1'b1;
      rows.push_back(o); rdys.push_back(rnd1());
      o = base(3'd3); o.rd_sel = str;
      rows.push_back(o); rdys.push_back(rnd1());

      if (op != 4'd15) begin
         o = base(3'd4);
         if (alu) o.alu_op = (m == 4'd8) ? 2'b01 : 2'b00;
         if (memop) o.alu_op = 2'b10;
         if (taken) begin
            o.pc_write = 1'b1;
            o.pc_sel   = 1'b1;
            o.br_sel   = (op != 4'd4);
         end
         rows.push_back(o); rdys.push_back(rnd1());

         if (memop) begin
            nmem = (k < int'(WMAX)) ? k + 1 : int'(WMAX);
            tmo  = (k >= int'(WMAX));
            for (int j = 0; j < nmem; j++) begin
               o = base(3'd5); o.mem_req = 1'b1; o.dm_we = str;
               rows.push_back(o); rdys.push_back(j >= k);
            end
         end else begin
            o = base(3'd5);
            rows.push_back(o); rdys.push_back(rnd1());
         end

         if (!tmo) begin
            o = base(3'd6); o.rf_we = alu || lod; o.wb_sel = lod;
            rows.push_back(o); rdys.push_back(rnd1());
         end
      end

      n = rows.size();
      if (cut > 0 && cut < n) n = cut;
      for (int i = 0; i < n; i++) push(rows[i], rdys[i], 1'b1, rnd1());
      if (n == rows.size()) begin
         to_halt = (op == 4'd15) || tmo;
         if (tmo) m_err = 1'b1;
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         checks++;
         if (got !== mon_e) begin
            errors++;
            $display("FAIL ctl cyc %0d got {%s} expected {%s}", cyc, fmt(got), fmt(mon_e));
         end
         cyc++;
      end
   end

   initial begin
      bit h;
      logic [3:0] rop;
      int k;
      rst_f = 1'b0; opcode = '0; mm = '0; stat = '0; mem_ready = 1'b0; resume = 1'b0;
      m_err = 1'b0;

      reset_seq(3);
      plan_instr(4'd8, 4'd8, 4'($urandom), 0, 0, h);          // ALU immediate
      plan_instr(4'd8, 4'd3, 4'($urandom), 0, 0, h);          // ALU register
      plan_instr(4'd1, 4'($urandom), 4'($urandom), 3, 0, h);  // LOD, 3 wait cycles
      plan_instr(4'd5, 4'b0001, 4'b0001, 0, 0, h);            // BRR taken
      plan_instr(4'd6, 4'b0001, 4'b0001, 0, 0, h);            // BNE not taken
      plan_instr(4'd4, 4'b0110, 4'b1001, 0, 0, h);            // BRA not taken
      plan_instr(4'd4, 4'b0110, 4'b0100, 0, 0, h);            // BRA taken
      plan_instr(4'd6, 4'b0010, 4'b1101, 0, 0, h);            // BNE taken
      plan_instr(4'd2, 4'($urandom), 4'($urandom), 0, 0, h);  // STR ready at once
      plan_instr(4'd1, 4'($urandom), 4'($urandom), int'(WMAX) - 1, 0, h); // ready on last cycle
      plan_instr(4'd3, 4'($urandom), 4'($urandom), 0, 0, h);  // undefined -> NOOP

      for (int i = 0; i < 30; i++) begin
         rop = 4'($urandom_range(0, 14));
         if ($urandom_range(0, 3) == 0) rop = ($urandom_range(0, 1) == 0) ? 4'd1 : 4'd2;
         k = ($urandom_range(0, 7) == 0) ? int'(WMAX) + int'($urandom_range(0, 3))
                                         : int'($urandom_range(0, 4));
         plan_instr(rop, 4'($urandom), 4'($urandom), k, 0, h);
         if (h) halt_exit(3);
      end

      plan_instr(4'd2, 4'($urandom), 4'($urandom), 30, 6, h); // abort mid-MEM wait
      reset_seq(2);
      plan_instr(4'd1, 4'($urandom), 4'($urandom), 0, 4, h);  // abort before WB
      reset_seq(2);
      plan_instr(4'd8, 4'd8, 4'($urandom), 0, 0, h);

      plan_instr(4'd2, 4'($urandom), 4'($urandom), int'(WMAX), 0, h); // timeout
      if (h) halt_exit(3);
      plan_instr(4'd15, 4'($urandom), 4'($urandom), 0, 0, h);         // HLT
      if (h) halt_exit(4);
      plan_instr(4'd8, 4'd2, 4'($urandom), 0, 0, h);
      plan_instr(4'd1, 4'($urandom), 4'($urandom), 1, 0, h);

      foreach (stim_q[i]) begin
         @(posedge clk);
         #1;
         rst_f     = stim_q[i].rst_f;
         opcode    = stim_q[i].opcode;
         mm        = stim_q[i].mm;
         stat      = stim_q[i].stat;
         mem_ready = stim_q[i].mem_ready;
         resume    = stim_q[i].resume;
         exp_q.push_back(stim_q[i].exp);
      end

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
